// File: rtl/core_sram_arbiter_if.sv
// IFU/LSU request bus and single-port SRAM bus for the core SRAM arbiter.
// slave = arbiter side; master = requesters plus SRAM macro.
interface core_sram_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              ls_req;
    logic              ls_we;
    logic [BE_W-1:0]   ls_be;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic              ls_gnt;
    logic              ls_rvalid;
    logic [DATA_W-1:0] ls_rdata;

    logic              sram_ce;
    logic              sram_we;
    logic [BE_W-1:0]   sram_be;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_be, ls_addr, ls_wdata, sram_rdata,
        output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
               sram_ce, sram_we, sram_be, sram_addr, sram_wdata
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_be, ls_addr, ls_wdata, sram_rdata,
        input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
               sram_ce, sram_we, sram_be, sram_addr, sram_wdata
    );
endinterface

// File: rtl/core_sram_arbiter.sv
// Fixed-priority (LSU first) arbiter for the shared SRAM, with IFU anti-starvation.
// Grant and SRAM command are same-cycle; read data returns 1 cycle after grant; a losing requester holds req.
module core_sram_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    core_sram_arbiter_if.slave     bus
);
    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IF_RD = 2'd1,
        LS_RD = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        starve_cnt_q, starve_cnt_d;

    logic              if_force;
    logic              if_gnt;
    logic              ls_gnt;
    logic              sram_ce;
    logic              sram_we;
    logic [BE_W-1:0]   sram_be;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic              if_rvalid;
    logic              ls_rvalid;

    // Grants are gated by rst_n so nothing reaches the SRAM while held in reset.
    always_comb begin
        if_force = (starve_cnt_q == 4'(STARVE_MAX));
        if_gnt   = 1'b0;
        ls_gnt   = 1'b0;
        if (rst_n) begin
            if (bus.if_req && (!bus.ls_req || if_force)) begin
                if_gnt = 1'b1;
            end else if (bus.ls_req) begin
                ls_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        sram_ce    = 1'b0;
        sram_we    = 1'b0;
        sram_be    = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (if_gnt) begin
            sram_ce   = 1'b1;
            sram_addr = bus.if_addr;
        end else if (ls_gnt) begin
            sram_ce    = 1'b1;
            sram_we    = bus.ls_we;
            sram_be    = bus.ls_we ? bus.ls_be : '0;
            sram_addr  = bus.ls_addr;
            sram_wdata = bus.ls_wdata;
        end
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!bus.if_req || if_gnt) begin
            starve_cnt_d = 4'd0;
        end else if (starve_cnt_q < 4'(STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    // Return pipeline: remembers who owns the data coming back next cycle.
    always_comb begin
        state_d = IDLE;
        if (if_gnt) begin
            state_d = IF_RD;
        end else if (ls_gnt && !bus.ls_we) begin
            state_d = LS_RD;
        end
        if_rvalid = rst_n && (state_q == IF_RD);
        ls_rvalid = rst_n && (state_q == LS_RD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            starve_cnt_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign bus.if_gnt     = if_gnt;
    assign bus.ls_gnt     = ls_gnt;
    assign bus.sram_ce    = sram_ce;
    assign bus.sram_we    = sram_we;
    assign bus.sram_be    = sram_be;
    assign bus.sram_addr  = sram_addr;
    assign bus.sram_wdata = sram_wdata;
    assign bus.if_rvalid  = if_rvalid;
    assign bus.ls_rvalid  = ls_rvalid;
    assign bus.if_rdata   = if_rvalid ? bus.sram_rdata : '0;
    assign bus.ls_rdata   = ls_rvalid ? bus.sram_rdata : '0;
endmodule

// File: tb/tb_core_sram_arbiter.sv
// Bench for core_sram_arbiter: SRAM behavioural model, per-scenario tasks, and a
// read-return scoreboard fed when a read grant is expected and drained on rvalid.
module tb_core_sram_arbiter;
    localparam int ADDR_W     = 14;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    core_sram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    core_sram_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        int          due;
        bit          is_if;
        logic [31:0] data;
    } ret_t;

    ret_t exp_q[$];
    int   vectors = 0;
    int   errors  = 0;
    int   cyc     = 0;

    // SRAM macro model with a backdoor preload port.
    logic [31:0] mem [0:(1<<ADDR_W)-1];
    logic        pl_en   = 1'b0;
    logic [13:0] pl_addr = '0;
    logic [31:0] pl_data = '0;
    logic [31:0] rd_q    = '0;
    assign bus.sram_rdata = rd_q;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pl_en) mem[pl_addr] <= pl_data;
        if (bus.sram_ce && bus.sram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.sram_be[b]) mem[bus.sram_addr][8*b +: 8] <= bus.sram_wdata[8*b +: 8];
            end
        end
        if (bus.sram_ce && !bus.sram_we) rd_q <= mem[bus.sram_addr];
    end

    // Scoreboard drain: every rvalid must match the oldest expected return.
    always @(negedge clk) begin
        ret_t        e;
        logic [31:0] got;
        #1;
        if (bus.if_rvalid || bus.ls_rvalid) begin
            if (exp_q.size() == 0) begin
                vectors++; errors++;
                $display("FAIL spurious_rvalid cyc=%0d if_rvalid=%b ls_rvalid=%b, none expected",
                         cyc, bus.if_rvalid, bus.ls_rvalid);
            end else begin
                e = exp_q.pop_front();
                vectors++;
                if ({bus.if_rvalid, bus.ls_rvalid} !== {e.is_if, !e.is_if} || e.due != cyc) begin
                    errors++;
                    $display("FAIL rvalid_owner cyc=%0d got if/ls=%b%b want %b%b due=%0d",
                             cyc, bus.if_rvalid, bus.ls_rvalid, e.is_if, !e.is_if, e.due);
                end
                got = e.is_if ? bus.if_rdata : bus.ls_rdata;
                vectors++;
                if (got !== e.data) begin
                    errors++;
                    $display("FAIL rdata cyc=%0d got=%h want=%h", cyc, got, e.data);
                end
            end
        end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
            e = exp_q.pop_front();
            vectors++; errors++;
            $display("FAIL missing_rvalid cyc=%0d want data=%h due=%0d", cyc, e.data, e.due);
        end
        if (!bus.if_rvalid) begin
            vectors++;
            if (bus.if_rdata !== 32'h0) begin
                errors++;
                $display("FAIL if_rdata_idle cyc=%0d got=%h want=0", cyc, bus.if_rdata);
            end
        end
        if (!bus.ls_rvalid) begin
            vectors++;
            if (bus.ls_rdata !== 32'h0) begin
                errors++;
                $display("FAIL ls_rdata_idle cyc=%0d got=%h want=0", cyc, bus.ls_rdata);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    function automatic logic [53:0] cmd();
        return {bus.if_gnt, bus.ls_gnt, bus.sram_ce, bus.sram_we,
                bus.sram_be, bus.sram_addr, bus.sram_wdata};
    endfunction

    task automatic drive_idle();
        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.ls_req   = 1'b0;
        bus.ls_we    = 1'b0;
        bus.ls_be    = '0;
        bus.ls_addr  = '0;
        bus.ls_wdata = '0;
    endtask

    task automatic preload(input logic [13:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic push_ret(input bit is_if, input logic [31:0] d);
        ret_t e;
        e.due = cyc + 1; e.is_if = is_if; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 14'h7;
        bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_be = 4'hF;
        bus.ls_addr = 14'h5; bus.ls_wdata = 32'hFFFF_FFFF;
        @(negedge clk); #1;
        vectors++;
        if (cmd() !== 54'h0) begin
            errors++; $display("FAIL reset_cmd got=%h want=0", cmd());
        end
        vectors++;
        if ({bus.if_rvalid, bus.ls_rvalid, bus.if_rdata, bus.ls_rdata} !== 66'h0) begin
            errors++; $display("FAIL reset_return got rv=%b%b want 00", bus.if_rvalid, bus.ls_rvalid);
        end
        vectors++;
        if (dut.starve_cnt_q !== 4'd0) begin
            errors++; $display("FAIL reset_starve got=%0d want=0", dut.starve_cnt_q);
        end
        drive_idle();
        rst_n = 1'b1;
        @(negedge clk); #1;
        vectors++;
        if (cmd() !== 54'h0) begin
            errors++; $display("FAIL post_reset_idle got=%h want=0", cmd());
        end
    endtask

    task automatic test_ifu_read();
        preload(14'h010, 32'hDEAD_BEEF);
        @(negedge clk);
        bus.if_req = 1'b1; bus.if_addr = 14'h010;
        push_ret(1'b1, 32'hDEAD_BEEF);
        #1;
        vectors++;
        if (cmd() !== {1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 14'h010, 32'h0}) begin
            errors++; $display("FAIL ifu_grant_cmd got=%h", cmd());
        end
        @(negedge clk);
        drive_idle();
        #1;
        vectors++;
        if (cmd() !== 54'h0) begin
            errors++; $display("FAIL ifu_after_idle got=%h want=0", cmd());
        end
    endtask

    task automatic test_lsu_write_read();
        preload(14'h020, 32'hAAAA_AAAA);
        @(negedge clk);
        bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_be = 4'b0011;
        bus.ls_addr = 14'h020; bus.ls_wdata = 32'h1234_5678;
        #1;
        vectors++;
        if (cmd() !== {1'b0, 1'b1, 1'b1, 1'b1, 4'b0011, 14'h020, 32'h1234_5678}) begin
            errors++; $display("FAIL lsu_write_cmd got=%h", cmd());
        end
        @(negedge clk);
        bus.ls_we = 1'b0;
        push_ret(1'b0, 32'hAAAA_5678);
        #1;
        vectors++;
        if (cmd() !== {1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 14'h020, 32'h1234_5678}) begin
            errors++; $display("FAIL lsu_read_cmd got=%h", cmd());
        end
        @(negedge clk);
        drive_idle();
        @(negedge clk);
    endtask

    task automatic test_contention();
        bit want_if;
        preload(14'h100, 32'hC0DE_0001);
        preload(14'h200, 32'h5A5A_0002);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            bus.if_req = 1'b1; bus.if_addr = 14'h100;
            bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_be = 4'hF; bus.ls_addr = 14'h200;
            want_if = ((k % 5) == 4);
            push_ret(want_if, want_if ? 32'hC0DE_0001 : 32'h5A5A_0002);
            #1;
            vectors++;
            if ({bus.if_gnt, bus.ls_gnt, bus.sram_we, bus.sram_be, bus.sram_addr} !==
                {want_if, !want_if, 1'b0, 4'h0, want_if ? 14'h100 : 14'h200}) begin
                errors++;
                $display("FAIL contention_grant k=%0d got if/ls=%b%b addr=%h be=%h want if=%b",
                         k, bus.if_gnt, bus.ls_gnt, bus.sram_addr, bus.sram_be, want_if);
            end
            vectors++;
            if (dut.starve_cnt_q !== 4'(k % 5)) begin
                errors++;
                $display("FAIL starve_cnt k=%0d got=%0d want=%0d", k, dut.starve_cnt_q, k % 5);
            end
        end
        @(negedge clk);
        drive_idle();
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) preload(14'(i), 32'hB0B0_0000 | 32'(i));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.if_req = 1'b1; bus.if_addr = 14'(i);
            push_ret(1'b1, 32'hB0B0_0000 | 32'(i));
            #1;
            vectors++;
            if ({bus.if_gnt, bus.ls_gnt, bus.sram_ce, bus.sram_addr} !== {3'b101, 14'(i)}) begin
                errors++;
                $display("FAIL b2b_grant i=%0d got gnt=%b ce=%b addr=%h", i, bus.if_gnt, bus.sram_ce, bus.sram_addr);
            end
        end
        @(negedge clk);
        drive_idle();
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        preload(14'h030, 32'h3333_3333);
        @(negedge clk);
        bus.if_req = 1'b1; bus.if_addr = 14'h030;
        #1;
        vectors++;
        if (bus.if_gnt !== 1'b1) begin
            errors++; $display("FAIL mid_reset_gnt got=%b want=1", bus.if_gnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.if_gnt, bus.sram_ce, bus.if_rvalid} !== 3'b000) begin
            errors++; $display("FAIL mid_reset_forced got gnt/ce/rv=%b%b%b want 000",
                               bus.if_gnt, bus.sram_ce, bus.if_rvalid);
        end
        drive_idle();
        @(negedge clk); #1;
        vectors++;
        if (bus.if_rvalid !== 1'b0) begin
            errors++; $display("FAIL mid_reset_rvalid got=%b want=0", bus.if_rvalid);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            vectors++;
            if ({cmd(), bus.if_rvalid, bus.ls_rvalid} !== 56'h0) begin
                errors++; $display("FAIL post_mid_reset i=%0d got cmd=%h rv=%b%b", i, cmd(),
                                   bus.if_rvalid, bus.ls_rvalid);
            end
        end
    endtask

    task automatic test_withdraw();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 14'h200;
            bus.if_req = (k == 2); bus.if_addr = 14'h100;
            push_ret(1'b0, 32'h5A5A_0002);
            #1;
            vectors++;
            if ({bus.if_gnt, bus.ls_gnt, bus.sram_ce, bus.sram_addr} !== {3'b011, 14'h200}) begin
                errors++;
                $display("FAIL withdraw_grant k=%0d got if/ls=%b%b ce=%b addr=%h",
                         k, bus.if_gnt, bus.ls_gnt, bus.sram_ce, bus.sram_addr);
            end
            if (k >= 3) begin
                vectors++;
                if (dut.starve_cnt_q !== ((k == 3) ? 4'd1 : 4'd0)) begin
                    errors++;
                    $display("FAIL withdraw_starve k=%0d got=%0d want=%0d", k, dut.starve_cnt_q, (k == 3) ? 1 : 0);
                end
            end
        end
        @(negedge clk);
        drive_idle();
        #1;
        vectors++;
        if (bus.sram_ce !== 1'b0) begin
            errors++; $display("FAIL withdraw_idle_ce got=%b want=0", bus.sram_ce);
        end
        @(negedge clk);
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_ifu_read();
        test_lsu_write_read();
        test_contention();
        test_back_to_back();
        test_reset_mid();
        test_withdraw();
        repeat (2) @(negedge clk);
        #2;
        vectors++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL leftover_returns got=%0d want=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/core_sram_arbiter.md
Name: core_sram_arbiter

Overview:
- Shares the core's single-port unified SRAM between two requesters: the instruction fetch unit (IFU) and the load/store unit (LSU).
- Arbitration is fixed-priority, with the LSU winning by default. A starvation counter guarantees the IFU forward progress.
- Sits inside core_pipe_top, between the pipeline stages and the SRAM macro, and is clocked by the pipeline clock.

Parameters:
- ADDR_W, 14, word-address width.
- DATA_W, 32, data width; byte enables are DATA_W/8 bits.
- STARVE_MAX, 4, consecutive denied IFU cycles before the IFU is forced priority (range 1..15).

Ports:
- clk  in  1  pipeline clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  IFU read request; held with if_addr stable until if_gnt.
- if_addr  in  ADDR_W  IFU word address.
- if_gnt  out  1  IFU request accepted this cycle.
- if_rvalid  out  1  if_rdata valid; one cycle after if_gnt.
- if_rdata  out  DATA_W  fetch data.
- ls_req  in  1  LSU request; held with its controls stable until ls_gnt.
- ls_we  in  1  1 = write, 0 = read.
- ls_be  in  DATA_W/8  byte enables for writes.
- ls_addr  in  ADDR_W  LSU word address.
- ls_wdata  in  DATA_W  write data.
- ls_gnt  out  1  LSU request accepted this cycle.
- ls_rvalid  out  1  ls_rdata valid; one cycle after ls_gnt on a read.
- ls_rdata  out  DATA_W  load data.
- sram_ce  out  1  SRAM access strobe.
- sram_we  out  1  SRAM write enable.
- sram_be  out  DATA_W/8  SRAM byte write mask.
- sram_addr  out  ADDR_W  SRAM address.
- sram_wdata  out  DATA_W  SRAM write data.
- sram_rdata  in  DATA_W  SRAM read data; valid the cycle after a read strobe.

Behaviour:
- Arbitration is combinational from the current requests and the registered starvation state. At most one grant is asserted per cycle, and the granted command is driven to the SRAM in the same cycle.
- Grant rules:
  - Neither requester: no grant, sram_ce=0.
  - IFU only: if_gnt=1.
  - LSU only: ls_gnt=1.
  - Both requesting and starve_cnt < STARVE_MAX: ls_gnt=1.
  - Both requesting and starve_cnt == STARVE_MAX: if_gnt=1.
- SRAM drive on grant:
  - sram_ce=1.
  - sram_addr = the winner's address.
  - IFU grant: sram_we=0, sram_be=0.
  - LSU grant: sram_we=ls_we; sram_be=ls_be when ls_we=1, otherwise 0; sram_wdata=ls_wdata.
- SRAM drive with no grant: sram_addr, sram_wdata and sram_be are 0, and sram_we=0.
- Starvation counter starve_cnt (4 bits):
  - Increments, saturating at STARVE_MAX, in each cycle with if_req=1 and if_gnt=0.
  - Clears to 0 on any cycle with if_gnt=1 or if_req=0.
- Read-return FSM, a registered 1-cycle pipeline of the last access owner:
  - States: IDLE, IF_RD, LS_RD.
  - Next state is IF_RD on if_gnt, LS_RD on an LSU read grant, otherwise IDLE. An LSU write returns to IDLE.
  - IF_RD asserts if_rvalid=1; LS_RD asserts ls_rvalid=1; IDLE asserts neither.
  - Back-to-back grants produce back-to-back rvalids; the state is updated every cycle.
- Read data:
  - if_rdata = sram_rdata while if_rvalid=1, else 0.
  - ls_rdata = sram_rdata while ls_rvalid=1, else 0.
- Writes complete on grant and produce no rvalid. A read granted the cycle after a write to the same address returns the new data, because ordering is the SRAM's.
- Throughput is one access per cycle. Read latency is 1 cycle from grant to rvalid.
- Reset:
  - While rst_n=0: if_gnt, ls_gnt, sram_ce, sram_we and both rvalids are forced to 0; sram_be, sram_addr, sram_wdata and both rdatas are 0.
  - The FSM goes to IDLE and starve_cnt to 0.
  - Reset asserted mid-access drops the pending rvalid. After release, arbitration resumes on the first clock edge with no stale return.
- A requester dropping req before grant is legal and is simply not served; the counter clears if it is the IFU.

Test Plan:
- IFU-only read: reset, mem[0x010]=0xDEADBEEF; if_req=1, if_addr=0x010 -> if_gnt=1 at cycle N and sram_ce=1, sram_addr=0x010; at N+1, if_rvalid=1 and if_rdata=0xDEADBEEF.
- LSU write then read: ls_we=1, ls_be=4'b0011, ls_addr=0x020, ls_wdata=0x12345678 over old 0xAAAAAAAA -> ls_gnt=1 with sram_we=1 and no ls_rvalid; next, an LSU read of 0x020 -> ls_rvalid=1 one cycle later with ls_rdata=0xAAAA5678.
- Contention and starvation with STARVE_MAX=4: both requesters held continuously -> ls_gnt for 4 cycles, if_gnt on the 5th, starve_cnt back to 0, then LSU wins for 4 more; rvalid owners alternate accordingly.
- Back-to-back: IFU reads 0x000, 0x001, 0x002 on consecutive cycles with no LSU request -> three consecutive if_gnt, then three consecutive if_rvalid with matching data.
- Reset mid-access: if_gnt on cycle N, rst_n=0 before edge N+1 -> if_rvalid stays 0; after release, all outputs are 0 until a new request arrives.
- Idle and withdraw: if_req pulsed for 1 cycle during a run of LSU grants, then dropped -> no if_gnt, starve_cnt=0, sram_ce tracks only LSU grants.
